// File: rtl/gpio_bank.sv
// GPIO bank: memory-mapped OUT/DIR/IN registers with edge-triggered sticky interrupt status.
// Latency: one-cycle ack after a hit; pin edges reach STATUS/irq 3 cycles after the pin change.
// Backpressure: none; a held request is re-acked every other cycle (ack, idle, ack).
module gpio_bank #(
  parameter int          WIDTH     = 8,
  parameter logic [31:0] BASE_ADDR = 32'h0300_0000
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             iomem_valid,
  output logic             iomem_ready,
  input  logic [3:0]       iomem_wstrb,
  input  logic [31:0]      iomem_addr,
  input  logic [31:0]      iomem_wdata,
  output logic [31:0]      iomem_rdata,
  input  logic [WIDTH-1:0] gpio_in,
  output logic [WIDTH-1:0] gpio_out,
  output logic [WIDTH-1:0] gpio_oe,
  output logic             irq
);

  localparam logic [2:0] REG_OUT    = 3'd0;
  localparam logic [2:0] REG_DIR    = 3'd1;
  localparam logic [2:0] REG_IN     = 3'd2;
  localparam logic [2:0] REG_RISE   = 3'd3;
  localparam logic [2:0] REG_FALL   = 3'd4;
  localparam logic [2:0] REG_STATUS = 3'd5;
  localparam logic [2:0] REG_SET    = 3'd6;
  localparam logic [2:0] REG_CLR    = 3'd7;

  logic             ready_q, ready_d;
  logic [WIDTH-1:0] out_q, out_d;
  logic [WIDTH-1:0] dir_q, dir_d;
  logic [WIDTH-1:0] rise_en_q, rise_en_d;
  logic [WIDTH-1:0] fall_en_q, fall_en_d;
  logic [WIDTH-1:0] status_q, status_d;
  logic [WIDTH-1:0] sync1_q, sync2_q, prev_q;

  logic             hit, accept, wr;
  logic [2:0]       sel;
  logic [31:0]      byte_mask, wbits;
  logic [WIDTH-1:0] wm, wv, rise, fall, evt, w1c;

  // Decode: the window is 32 bytes, so only address bits above 4 identify the bank.
  assign hit       = iomem_valid && (iomem_addr[31:5] == BASE_ADDR[31:5]);
  // A request is only taken while no ack is showing, which forces an idle cycle between acks.
  assign accept    = hit && !ready_q;
  assign wr        = accept && (iomem_wstrb != 4'b0000);
  assign sel       = iomem_addr[4:2];
  assign byte_mask = {{8{iomem_wstrb[3]}}, {8{iomem_wstrb[2]}},
                      {8{iomem_wstrb[1]}}, {8{iomem_wstrb[0]}}};
  assign wbits     = iomem_wdata & byte_mask;
  // Bits at or above WIDTH simply have no storage, so they are dropped here.
  assign wm        = byte_mask[WIDTH-1:0];
  assign wv        = wbits[WIDTH-1:0];

  // Edges are seen between the second sync stage and the prev flop.
  assign rise = sync2_q & ~prev_q;
  assign fall = ~sync2_q & prev_q;
  assign evt  = (rise & rise_en_q) | (fall & fall_en_q);

  // Next-state for the register file; a set event is OR-ed in after the W1C so it wins.
  always_comb begin
    ready_d   = accept;
    out_d     = out_q;
    dir_d     = dir_q;
    rise_en_d = rise_en_q;
    fall_en_d = fall_en_q;
    w1c       = '0;
    if (wr) begin
      case (sel)
        REG_OUT:    out_d     = (out_q & ~wm) | wv;
        REG_DIR:    dir_d     = (dir_q & ~wm) | wv;
        REG_RISE:   rise_en_d = (rise_en_q & ~wm) | wv;
        REG_FALL:   fall_en_d = (fall_en_q & ~wm) | wv;
        REG_STATUS: w1c       = wv;
        REG_SET:    out_d     = out_q | wv;
        REG_CLR:    out_d     = out_q & ~wv;
        default:    ;
      endcase
    end
    status_d = (status_q & ~w1c) | evt;
  end

  // State registers, synchroniser and prev flop; reset also drops any in-flight access.
  always_ff @(posedge clk) begin
    if (reset) begin
      ready_q   <= 1'b0;
      out_q     <= '0;
      dir_q     <= '0;
      rise_en_q <= '0;
      fall_en_q <= '0;
      status_q  <= '0;
      sync1_q   <= '0;
      sync2_q   <= '0;
      prev_q    <= '0;
    end else begin
      ready_q   <= ready_d;
      out_q     <= out_d;
      dir_q     <= dir_d;
      rise_en_q <= rise_en_d;
      fall_en_q <= fall_en_d;
      status_q  <= status_d;
      sync1_q   <= gpio_in;
      sync2_q   <= sync1_q;
      prev_q    <= sync2_q;
    end
  end

  // Read mux: the selected register, zero-extended, only while the ack is showing.
  always_comb begin
    iomem_rdata = '0;
    if (ready_q) begin
      case (sel)
        REG_OUT:    iomem_rdata[WIDTH-1:0] = out_q;
        REG_DIR:    iomem_rdata[WIDTH-1:0] = dir_q;
        REG_IN:     iomem_rdata[WIDTH-1:0] = sync2_q;
        REG_RISE:   iomem_rdata[WIDTH-1:0] = rise_en_q;
        REG_FALL:   iomem_rdata[WIDTH-1:0] = fall_en_q;
        REG_STATUS: iomem_rdata[WIDTH-1:0] = status_q;
        default:    iomem_rdata = '0;
      endcase
    end
  end

  assign iomem_ready = ready_q;
  assign gpio_out    = out_q;
  assign gpio_oe     = dir_q;
  assign irq         = |status_q;

  // Byte-offset bits and data bits beyond WIDTH are intentionally unused.
  logic unused_ok;
  assign unused_ok = ^{iomem_addr[1:0], wbits, byte_mask};

endmodule

// File: tb/tb_gpio_bank.sv
module tb_gpio_bank;
  localparam int          WIDTH = 8;
  localparam logic [31:0] BASE  = 32'h0300_0000;

  logic             clk = 1'b0;
  logic             reset = 1'b1;
  logic             iomem_valid = 1'b0;
  logic             iomem_ready;
  logic [3:0]       iomem_wstrb = 4'b0;
  logic [31:0]      iomem_addr = '0;
  logic [31:0]      iomem_wdata = '0;
  logic [31:0]      iomem_rdata;
  logic [WIDTH-1:0] gpio_in = '0;
  logic [WIDTH-1:0] gpio_out;
  logic [WIDTH-1:0] gpio_oe;
  logic             irq;

  int checks = 0;
  int errors = 0;

  gpio_bank #(.WIDTH(WIDTH), .BASE_ADDR(BASE)) dut (
    .clk(clk), .reset(reset),
    .iomem_valid(iomem_valid), .iomem_ready(iomem_ready),
    .iomem_wstrb(iomem_wstrb), .iomem_addr(iomem_addr),
    .iomem_wdata(iomem_wdata), .iomem_rdata(iomem_rdata),
    .gpio_in(gpio_in), .gpio_out(gpio_out), .gpio_oe(gpio_oe), .irq(irq)
  );

  always #5 clk = ~clk;

  // One access: request at negedge, sample ack/data 1ns after the next posedge,
  // then one more edge so the ack has dropped before the next access.
  task automatic bus(input logic [31:0] addr, input logic [31:0] wdata,
                     input logic [3:0] wstrb, output logic acked, output logic [31:0] rdata);
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = addr; iomem_wdata = wdata; iomem_wstrb = wstrb;
    @(posedge clk); #1;
    acked = iomem_ready; rdata = iomem_rdata;
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
    @(posedge clk); #1;
  endtask

  task automatic test_reset();
    repeat (3) @(posedge clk);
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL reset_gpio_out: got %h expected 00", gpio_out); end
    checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL reset_gpio_oe: got %h expected 00", gpio_oe); end
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL reset_irq: got %b expected 0", irq); end
    checks++; if (iomem_rdata !== 32'h0) begin errors++; $display("FAIL reset_rdata: got %h expected 0", iomem_rdata); end
    checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL reset_ready: got %b expected 0", iomem_ready); end
  endtask

  task automatic test_write_read();
    logic a; logic [31:0] d;
    bus(BASE + 32'h00, 32'h0000_00A5, 4'b0001, a, d);
    checks++; if (a !== 1'b1) begin errors++; $display("FAIL wr_out_ack: got %b expected 1", a); end
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL wr_out_gpio: got %h expected a5", gpio_out); end
    bus(BASE + 32'h00, 32'h0, 4'b0000, a, d);
    checks++; if (d !== 32'h0000_00A5) begin errors++; $display("FAIL rd_out: got %h expected 000000a5", d); end
    // Strobe on a byte beyond WIDTH only: OUT must not change.
    bus(BASE + 32'h00, 32'h0000_3C5A, 4'b0010, a, d);
    checks++; if (gpio_out !== 8'hA5) begin errors++; $display("FAIL wr_strobe_mask: got %h expected a5", gpio_out); end
  endtask

  task automatic test_set_clr();
    logic a; logic [31:0] d;
    bus(BASE + 32'h00, 32'h0000_00F0, 4'b0001, a, d);
    bus(BASE + 32'h18, 32'h0000_0003, 4'b0001, a, d);
    checks++; if (gpio_out !== 8'hF3) begin errors++; $display("FAIL set_out: got %h expected f3", gpio_out); end
    bus(BASE + 32'h1C, 32'h0000_0010, 4'b0001, a, d);
    checks++; if (gpio_out !== 8'hE3) begin errors++; $display("FAIL clr_out: got %h expected e3", gpio_out); end
    bus(BASE + 32'h18, 32'h0, 4'b0000, a, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rd_set_zero: got %h expected 0", d); end
  endtask

  task automatic test_rise_irq();
    logic a; logic [31:0] d;
    bus(BASE + 32'h0C, 32'h0000_0001, 4'b0001, a, d);
    @(negedge clk); gpio_in[0] = 1'b1;
    @(posedge clk); #1;
    @(posedge clk); #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rise_irq_cycle2: got %b expected 0", irq); end
    @(posedge clk); #1;
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL rise_irq_cycle3: got %b expected 1", irq); end
    bus(BASE + 32'h14, 32'h0, 4'b0000, a, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL rise_status: got %h expected 00000001", d); end
    bus(BASE + 32'h08, 32'h0, 4'b0000, a, d);
    checks++; if (d !== 32'h0000_0001) begin errors++; $display("FAIL rd_in: got %h expected 00000001", d); end
    bus(BASE + 32'h14, 32'h0000_0001, 4'b0001, a, d);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL w1c_irq: got %b expected 0", irq); end
  endtask

  task automatic test_fall_vs_w1c();
    logic a; logic [31:0] d;
    bus(BASE + 32'h10, 32'h0000_0002, 4'b0001, a, d);
    @(negedge clk); gpio_in[1] = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fall_pre_irq: got %b expected 0", irq); end
    @(negedge clk); gpio_in[1] = 1'b0;
    @(posedge clk);
    @(posedge clk);
    // The W1C lands on the third edge, the same edge the fall event sets STATUS[1].
    bus(BASE + 32'h14, 32'h0000_0002, 4'b0001, a, d);
    checks++; if (irq !== 1'b1) begin errors++; $display("FAIL fall_wins_irq: got %b expected 1", irq); end
    bus(BASE + 32'h14, 32'h0000_0000, 4'b0001, a, d);
    bus(BASE + 32'h14, 32'h0, 4'b0000, a, d);
    checks++; if (d !== 32'h0000_0002) begin errors++; $display("FAIL fall_status: got %h expected 00000002", d); end
    bus(BASE + 32'h14, 32'h0000_0002, 4'b0001, a, d);
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL fall_clear_irq: got %b expected 0", irq); end
  endtask

  task automatic test_back_to_back();
    logic a; logic [31:0] d;
    logic [3:0] pat;
    @(negedge clk);
    iomem_valid = 1'b1; iomem_addr = BASE + 32'h04; iomem_wstrb = 4'b0000;
    #1 pat[3] = iomem_ready;
    @(posedge clk); #1 pat[2] = iomem_ready;
    @(posedge clk); #1 pat[1] = iomem_ready;
    @(posedge clk); #1 pat[0] = iomem_ready;
    iomem_valid = 1'b0;
    @(posedge clk); #1;
    checks++; if (pat !== 4'b0101) begin errors++; $display("FAIL held_valid_pattern: got %b expected 0101", pat); end
    bus(BASE + 32'h20, 32'h0000_00FF, 4'b0001, a, d);
    checks++; if (a !== 1'b0) begin errors++; $display("FAIL miss_ack: got %b expected 0", a); end
    checks++; if (gpio_out !== 8'hE3) begin errors++; $display("FAIL miss_no_write: got %h expected e3", gpio_out); end
  endtask

  task automatic test_width_and_reset();
    logic a; logic [31:0] d;
    bus(BASE + 32'h04, 32'hFFFF_FFFF, 4'b1111, a, d);
    checks++; if (gpio_oe !== 8'hFF) begin errors++; $display("FAIL dir_oe: got %h expected ff", gpio_oe); end
    bus(BASE + 32'h04, 32'h0, 4'b0000, a, d);
    checks++; if (d !== 32'h0000_00FF) begin errors++; $display("FAIL dir_readback: got %h expected 000000ff", d); end
    // Reset asserted on the edge that would have accepted a write.
    @(negedge clk);
    reset = 1'b1;
    iomem_valid = 1'b1; iomem_addr = BASE + 32'h00; iomem_wdata = 32'h55; iomem_wstrb = 4'b0001;
    @(posedge clk); #1;
    checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL rst_mid_ack: got %b expected 0", iomem_ready); end
    iomem_valid = 1'b0; iomem_wstrb = 4'b0;
    @(negedge clk); reset = 1'b0;
    @(posedge clk); #1;
    checks++; if (iomem_ready !== 1'b0) begin errors++; $display("FAIL rst_post_ack: got %b expected 0", iomem_ready); end
    checks++; if (gpio_out !== 8'h00) begin errors++; $display("FAIL rst_out: got %h expected 00", gpio_out); end
    checks++; if (gpio_oe !== 8'h00) begin errors++; $display("FAIL rst_dir: got %h expected 00", gpio_oe); end
    bus(BASE + 32'h0C, 32'h0, 4'b0000, a, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_rise_en: got %h expected 0", d); end
    bus(BASE + 32'h10, 32'h0, 4'b0000, a, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_fall_en: got %h expected 0", d); end
    // gpio_in[0] stayed high through reset: no status may appear.
    repeat (4) @(posedge clk);
    #1;
    checks++; if (irq !== 1'b0) begin errors++; $display("FAIL rst_pin_high_irq: got %b expected 0", irq); end
    bus(BASE + 32'h14, 32'h0, 4'b0000, a, d);
    checks++; if (d !== 32'h0) begin errors++; $display("FAIL rst_status: got %h expected 0", d); end
  endtask

  initial begin
    test_reset();
    test_write_read();
    test_set_clr();
    test_rise_irq();
    test_fall_vs_w1c();
    test_back_to_back();
    test_width_and_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
